// File: rtl/mem_rr_arbiter_if.sv
// Bundled handshake signals between CNT requesters, the arbiter and one memory slave.
// The arbiter connects through the slave modport; the environment drives through master.
interface mem_rr_arbiter_if #(
  parameter int CNT        = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int ReqW = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic [CNT-1:0]                 m_req_valid;
  logic [CNT-1:0]                 m_req_ready;
  logic [CNT-1:0][ReqW-1:0]       m_req_data;
  logic [CNT-1:0]                 m_resp_valid;
  logic [CNT-1:0]                 m_resp_ready;
  logic [CNT-1:0][DATA_WIDTH-1:0] m_resp_data;
  logic                           s_req_valid;
  logic                           s_req_ready;
  logic [ReqW-1:0]                s_req_data;
  logic                           s_resp_valid;
  logic                           s_resp_ready;
  logic [DATA_WIDTH-1:0]          s_resp_data;

  modport slave (
    input  m_req_valid, m_req_data, m_resp_ready, s_req_ready, s_resp_valid, s_resp_data,
    output m_req_ready, m_resp_valid, m_resp_data, s_req_valid, s_req_data, s_resp_ready
  );

  modport master (
    output m_req_valid, m_req_data, m_resp_ready, s_req_ready, s_resp_valid, s_resp_data,
    input  m_req_ready, m_resp_valid, m_resp_data, s_req_valid, s_req_data, s_resp_ready
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// CNT-to-1 memory request arbiter with grant locking and an in-order ID queue that
// routes each slave response back to the master whose request it answers.
module mem_rr_arbiter #(
  parameter int CNT         = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  mem_rr_arbiter_if.slave                    bus,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   outstanding,
  output logic                               orphan_err
);
  localparam int IdW  = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CntW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              r_state, w_state_d;
  logic [IdW-1:0]      r_lock_idx, r_rr_ptr;
  logic [IdW-1:0]      r_queue [QUEUE_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic                r_orphan;

  logic [IdW-1:0]      w_arb_idx, w_grant, w_head;
  logic                w_found, w_full, w_empty, w_req_valid, w_fire, w_deq;
  int unsigned         w_idx;

  assign w_full  = (r_count == CntW'(QUEUE_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_queue[r_rd_ptr];

  // Unlocked grant: fixed priority or first valid at/after r_rr_ptr with wrap.
  always_comb begin
    w_arb_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    if (ARB_MODE == 0) begin
      for (int i = CNT - 1; i >= 0; i--) begin
        if (bus.m_req_valid[i]) w_arb_idx = IdW'(i);
      end
    end else begin
      for (int k = 0; k < CNT; k++) begin
        w_idx = (int'(r_rr_ptr) + k) % CNT;
        if (!w_found && bus.m_req_valid[w_idx]) begin
          w_arb_idx = IdW'(w_idx);
          w_found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_grant     = w_arb_idx;
    w_req_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_valid = (|bus.m_req_valid) && !w_full && !rst;
        if (w_req_valid && !bus.s_req_ready) w_state_d = StLocked;
      end
      StLocked: begin
        w_grant     = r_lock_idx;
        w_req_valid = bus.m_req_valid[r_lock_idx] && !w_full && !rst;
        // Leaving on a dropped request tolerates masters that withdraw mid-handshake.
        if ((w_req_valid && bus.s_req_ready) || !bus.m_req_valid[r_lock_idx]) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_fire          = w_req_valid && bus.s_req_ready;
  assign bus.s_req_valid = w_req_valid;
  assign bus.s_req_data  = bus.m_req_data[w_grant];

  assign bus.s_resp_ready = !w_empty && bus.m_resp_ready[w_head] && !rst;
  assign w_deq            = bus.s_resp_valid && bus.s_resp_ready;

  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      bus.m_req_ready[i]  = w_fire && (w_grant == IdW'(i));
      bus.m_resp_valid[i] = bus.s_resp_valid && !w_empty && (w_head == IdW'(i)) && !rst;
      bus.m_resp_data[i]  = bus.s_resp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_orphan   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle) r_lock_idx <= w_arb_idx;
      if (w_fire) begin
        r_rr_ptr <= (w_grant == IdW'(CNT - 1)) ? '0 : w_grant + 1'b1;
        r_wr_ptr <= (r_wr_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_fire, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.s_resp_valid && w_empty) r_orphan <= 1'b1;
    end
  end

  // ID storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_fire) r_queue[r_wr_ptr] <= w_grant;
  end

  assign outstanding = r_count;
  assign orphan_err  = r_orphan;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench: dut_a is round-robin with depth 4, dut_b is fixed priority with depth 2.
module tb_mem_rr_arbiter;
  logic clk, rst;
  logic [2:0] out_a;
  logic [1:0] out_b;
  logic orphan_a, orphan_b;
  int n_cmp, n_fail;

  mem_rr_arbiter_if #(.CNT(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  mem_rr_arbiter_if #(.CNT(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  mem_rr_arbiter #(.CNT(4), .QUEUE_DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a), .outstanding(out_a), .orphan_err(orphan_a));
  mem_rr_arbiter #(.CNT(4), .QUEUE_DEPTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .outstanding(out_b), .orphan_err(orphan_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] req_word(int i);
    return {1'(i & 1), 32'h1000 + 32'(i), 32'hA0 + 32'(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.m_req_valid = '0; bus_a.s_req_ready = 1'b0; bus_a.s_resp_valid = 1'b0;
    bus_a.m_resp_ready = 4'hF; bus_a.s_resp_data = '0;
    bus_b.m_req_valid = '0; bus_b.s_req_ready = 1'b0; bus_b.s_resp_valid = 1'b0;
    bus_b.m_resp_ready = 4'hF; bus_b.s_resp_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.m_req_valid = 4'hF; bus_a.s_req_ready = 1'b1; bus_a.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_a.s_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_sreq_valid got %b want 0", bus_a.s_req_valid); end
    n_cmp++; if (bus_a.m_req_ready !== 4'h0) begin n_fail++;
      $display("FAIL reset_mreq_ready got %b want 0000", bus_a.m_req_ready); end
    n_cmp++; if (bus_a.s_resp_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_sresp_ready got %b want 0", bus_a.s_resp_ready); end
    n_cmp++; if (bus_a.m_resp_valid !== 4'h0) begin n_fail++;
      $display("FAIL reset_mresp_valid got %b want 0000", bus_a.m_resp_valid); end
    n_cmp++; if (out_a !== 3'd0 || orphan_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_state got out=%0d orphan=%b want 0/0", out_a, orphan_a); end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_rr_fairness();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      bus_a.m_req_valid = 4'hF; bus_a.s_req_ready = 1'b1;
      bus_a.s_resp_valid = (k > 0); bus_a.s_resp_data = 32'hD00 + 32'(k);
      #2;
      n_cmp++; if (bus_a.m_req_ready !== 4'(1 << exp_g[k])) begin n_fail++;
        $display("FAIL rr_grant[%0d] got %b want %b", k, bus_a.m_req_ready, 4'(1 << exp_g[k])); end
      n_cmp++; if (bus_a.s_req_data !== req_word(exp_g[k])) begin n_fail++;
        $display("FAIL rr_data[%0d] got %h want %h", k, bus_a.s_req_data, req_word(exp_g[k])); end
      if (k > 0) begin
        n_cmp++; if (bus_a.m_resp_valid !== 4'(1 << exp_g[k-1])) begin n_fail++;
          $display("FAIL rr_resp_route[%0d] got %b want %b", k, bus_a.m_resp_valid,
                   4'(1 << exp_g[k-1])); end
      end
      step();
    end
    bus_a.m_req_valid = 4'h0; bus_a.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_a.m_resp_valid !== 4'b0001) begin n_fail++;
      $display("FAIL rr_drain_route got %b want 0001", bus_a.m_resp_valid); end
    step();
    bus_a.s_resp_valid = 1'b0; bus_a.s_req_ready = 1'b0;
    #2;
    n_cmp++; if (out_a !== 3'd0 || orphan_a !== 1'b0) begin n_fail++;
      $display("FAIL rr_final got out=%0d orphan=%b want 0/0", out_a, orphan_a); end
    step();
  endtask

  task automatic test_grant_lock();
    bus_a.s_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus_a.m_req_valid = (c == 0) ? 4'b0100 : 4'b0101;
      #2;
      n_cmp++; if (bus_a.s_req_valid !== 1'b1 || bus_a.s_req_data !== req_word(2)) begin
        n_fail++; $display("FAIL lock_hold[%0d] got v=%b d=%h want 1/%h", c,
                           bus_a.s_req_valid, bus_a.s_req_data, req_word(2)); end
      n_cmp++; if (bus_a.m_req_ready !== 4'h0) begin n_fail++;
        $display("FAIL lock_ready[%0d] got %b want 0000", c, bus_a.m_req_ready); end
      step();
    end
    bus_a.s_req_ready = 1'b1;
    #2;
    n_cmp++; if (bus_a.m_req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL lock_fire got %b want 0100", bus_a.m_req_ready); end
    step();
    bus_a.m_req_valid = 4'b0001;
    #2;
    n_cmp++; if (bus_a.m_req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL lock_next got %b want 0001", bus_a.m_req_ready); end
    step();
    bus_a.m_req_valid = 4'h0; bus_a.s_req_ready = 1'b0; bus_a.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_a.m_resp_valid !== 4'b0100) begin n_fail++;
      $display("FAIL lock_resp0 got %b want 0100", bus_a.m_resp_valid); end
    step();
    #2;
    n_cmp++; if (bus_a.m_resp_valid !== 4'b0001) begin n_fail++;
      $display("FAIL lock_resp1 got %b want 0001", bus_a.m_resp_valid); end
    step();
    bus_a.s_resp_valid = 1'b0;
  endtask

  task automatic test_in_order_routing();
    int          src[3]  = '{3, 1, 3};
    logic [31:0] dat[4]  = '{32'hD0, 32'hD1, 32'hD1, 32'hD2};
    logic [3:0]  mrr[4]  = '{4'hF, 4'b1101, 4'hF, 4'hF};
    logic [3:0]  expv[4] = '{4'b1000, 4'b0010, 4'b0010, 4'b1000};
    logic        exps[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          dst[4]  = '{3, 1, 1, 3};
    for (int k = 0; k < 3; k++) begin
      bus_a.m_req_valid = 4'(1 << src[k]); bus_a.s_req_ready = 1'b1;
      #2;
      n_cmp++; if (bus_a.m_req_ready !== 4'(1 << src[k])) begin n_fail++;
        $display("FAIL route_req[%0d] got %b want %b", k, bus_a.m_req_ready,
                 4'(1 << src[k])); end
      step();
    end
    bus_a.m_req_valid = 4'h0; bus_a.s_req_ready = 1'b0;
    #2;
    n_cmp++; if (out_a !== 3'd3) begin n_fail++;
      $display("FAIL route_outstanding got %0d want 3", out_a); end
    for (int k = 0; k < 4; k++) begin
      bus_a.s_resp_valid = 1'b1; bus_a.s_resp_data = dat[k]; bus_a.m_resp_ready = mrr[k];
      #2;
      n_cmp++; if (bus_a.m_resp_valid !== expv[k] || bus_a.s_resp_ready !== exps[k]) begin
        n_fail++; $display("FAIL route_resp[%0d] got v=%b r=%b want %b/%b", k,
                           bus_a.m_resp_valid, bus_a.s_resp_ready, expv[k], exps[k]); end
      n_cmp++; if (bus_a.m_resp_data[dst[k]] !== dat[k]) begin n_fail++;
        $display("FAIL route_data[%0d] got %h want %h", k, bus_a.m_resp_data[dst[k]], dat[k]); end
      step();
    end
    bus_a.s_resp_valid = 1'b0; bus_a.m_resp_ready = 4'hF;
    #2;
    n_cmp++; if (out_a !== 3'd0) begin n_fail++;
      $display("FAIL route_drained got %0d want 0", out_a); end
    step();
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k < 4; k++) begin
      bus_b.m_req_valid = 4'b0110; bus_b.s_req_ready = 1'b1; bus_b.s_resp_valid = (k > 0);
      #2;
      n_cmp++; if (bus_b.m_req_ready !== 4'b0010 || bus_b.s_req_data !== req_word(1)) begin
        n_fail++; $display("FAIL fixed_grant[%0d] got r=%b d=%h want 0010/%h", k,
                           bus_b.m_req_ready, bus_b.s_req_data, req_word(1)); end
      step();
    end
    bus_b.m_req_valid = 4'h0; bus_b.s_req_ready = 1'b0;
    step();
    bus_b.s_resp_valid = 1'b0;
    #2;
    n_cmp++; if (out_b !== 2'd0 || orphan_b !== 1'b0) begin n_fail++;
      $display("FAIL fixed_drained got out=%0d orphan=%b want 0/0", out_b, orphan_b); end
    step();
  endtask

  task automatic test_queue_full();
    bus_b.m_req_valid = 4'b0001; bus_b.s_req_ready = 1'b1;
    step();
    #2;
    n_cmp++; if (bus_b.s_req_valid !== 1'b1 || out_b !== 2'd1) begin n_fail++;
      $display("FAIL full_second got v=%b out=%0d want 1/1", bus_b.s_req_valid, out_b); end
    step();
    #2;
    n_cmp++; if (bus_b.s_req_valid !== 1'b0 || out_b !== 2'd2 || bus_b.m_req_ready !== 4'h0)
      begin n_fail++; $display("FAIL full_block got v=%b out=%0d r=%b want 0/2/0000",
                               bus_b.s_req_valid, out_b, bus_b.m_req_ready); end
    step();
    bus_b.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_b.s_req_valid !== 1'b0 || bus_b.s_resp_ready !== 1'b1) begin n_fail++;
      $display("FAIL full_deq_cycle got v=%b rr=%b want 0/1", bus_b.s_req_valid,
               bus_b.s_resp_ready); end
    step();
    bus_b.s_resp_valid = 1'b0;
    #2;
    n_cmp++; if (out_b !== 2'd1 || bus_b.m_req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL full_refill got out=%0d r=%b want 1/0001", out_b, bus_b.m_req_ready); end
    step();
    bus_b.m_req_valid = 4'h0;
    #2;
    n_cmp++; if (out_b !== 2'd2) begin n_fail++;
      $display("FAIL full_again got %0d want 2", out_b); end
    bus_b.s_resp_valid = 1'b1;
    step();
    step();
    bus_b.s_resp_valid = 1'b0; bus_b.s_req_ready = 1'b0;
    #2;
    n_cmp++; if (out_b !== 2'd0) begin n_fail++;
      $display("FAIL full_drained got %0d want 0", out_b); end
    step();
  endtask

  task automatic test_orphan();
    bus_a.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_a.s_resp_ready !== 1'b0 || bus_a.m_resp_valid !== 4'h0) begin n_fail++;
      $display("FAIL orphan_block got r=%b v=%b want 0/0000", bus_a.s_resp_ready,
               bus_a.m_resp_valid); end
    step();
    bus_a.s_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (orphan_a !== 1'b1) begin n_fail++;
        $display("FAIL orphan_sticky[%0d] got %b want 1", c, orphan_a); end
      step();
    end
    bus_a.m_req_valid = 4'b0001; bus_a.s_req_ready = 1'b1;
    step();
    bus_a.m_req_valid = 4'h0; bus_a.s_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_a !== 3'd0 || orphan_a !== 1'b0) begin n_fail++;
      $display("FAIL async_reset got out=%0d orphan=%b want 0/0", out_a, orphan_a); end
    step();
    rst = 1'b0;
    bus_a.s_resp_valid = 1'b1;
    #2;
    n_cmp++; if (bus_a.s_resp_ready !== 1'b0 || bus_a.m_resp_valid !== 4'h0) begin n_fail++;
      $display("FAIL post_reset_orphan got r=%b v=%b want 0/0000", bus_a.s_resp_ready,
               bus_a.m_resp_valid); end
    step();
    bus_a.s_resp_valid = 1'b0;
    #2;
    n_cmp++; if (orphan_a !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_flag got %b want 1", orphan_a); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.m_req_data[i] = req_word(i);
      bus_b.m_req_data[i] = req_word(i);
    end
    idle_inputs();
    #1;
    test_reset();
    test_rr_fairness();
    test_grant_lock();
    test_in_order_routing();
    test_fixed_priority();
    test_queue_full();
    test_orphan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
